// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states, lane masks.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE0 = 3'd1,
      S_WAIT0  = 3'd2,
      S_ISSUE1 = 3'd3,
      S_WAIT1  = 3'd4,
      S_DONE   = 3'd5
   } lsu_state_e;

   // Lane mask at offset 0; the size lives in funct3[1:0] for loads and stores alike.
   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return MASK_B;
         2'd1:    return MASK_H;
         2'd2:    return MASK_W;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// master = core plus memory environment, slave = the load/store unit itself.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store strobes/data for both halves, load merge and extension.
// Two halves are treated as one 64-bit window starting at lane 0 of the first word.
module load_store_unit_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata0,
   input  logic [31:0] i_rdata1,
   output logic        o_cross,
   output logic [3:0]  o_we0,
   output logic [3:0]  o_we1,
   output logic [31:0] o_wdata0,
   output logic [31:0] o_wdata1,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_mask8;
   logic [63:0] w_wdata64;
   logic [31:0] w_merged;

   assign w_mask8   = {4'b0000, size_mask(i_funct3)} << i_offset;
   assign w_wdata64 = {32'd0, i_wdata} << {i_offset, 3'b000};

   assign o_we0    = w_mask8[3:0];
   assign o_we1    = w_mask8[7:4];
   assign o_cross  = |w_mask8[7:4];
   assign o_wdata0 = w_wdata64[31:0];
   assign o_wdata1 = w_wdata64[63:32];

   assign w_merged = 32'({i_rdata1, i_rdata0} >> {i_offset, 3'b000});

   always_comb begin
      o_rdata = '0;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_merged[7]}}, w_merged[7:0]};
         F3_H:    o_rdata = {{16{w_merged[15]}}, w_merged[15:0]};
         F3_W:    o_rdata = w_merged;
         F3_BU:   o_rdata = {24'd0, w_merged[7:0]};
         F3_HU:   o_rdata = {16'd0, w_merged[15:0]};
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one request at a time, split misaligned accesses, registered one-cycle response.
// Load 3/5 cycles, store 2/3 cycles, error 1 cycle after accept; req_ready only in IDLE, response has no backpressure.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   localparam int WIDX_W = ADDR_W - 2;

   lsu_state_e        r_state;
   lsu_state_e        w_state_nxt;

   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_err;
   logic [31:0]       r_rdata0;
   logic [31:0]       r_rdata1;

   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_accept;
   logic              w_req_err;
   logic              w_cross;
   logic [3:0]        w_we0;
   logic [3:0]        w_we1;
   logic [31:0]       w_wdata0;
   logic [31:0]       w_wdata1;
   logic [31:0]       w_load_data;
   logic [WIDX_W-1:0] w_widx;

   assign w_accept  = bus.req_valid && (r_state == S_IDLE);
   assign w_req_err = !funct3_legal(bus.req_we, bus.req_funct3) ||
                      (!MISALIGN_SPLIT && is_misaligned(bus.req_funct3, bus.req_addr[1:0]));
   assign w_widx    = r_addr[ADDR_W-1:2];

   load_store_unit_lane_align u_lane_align (
      .i_offset (r_addr[1:0]),
      .i_funct3 (r_funct3),
      .i_wdata  (r_wdata),
      .i_rdata0 (r_rdata0),
      .i_rdata1 (r_rdata1),
      .o_cross  (w_cross),
      .o_we0    (w_we0),
      .o_we1    (w_we1),
      .o_wdata0 (w_wdata0),
      .o_wdata1 (w_wdata1),
      .o_rdata  (w_load_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // mem_en/mem_we come straight from state so an async reset drops them at once.
   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 4'b0000;
      bus.mem_addr  = w_widx;
      bus.mem_wdata = w_wdata0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               w_state_nxt = w_req_err ? S_DONE : S_ISSUE0;
         end
         S_ISSUE0: begin
            bus.mem_en = 1'b1;
            if (r_we) begin
               bus.mem_we  = w_we0;
               w_state_nxt = w_cross ? S_ISSUE1 : S_DONE;
            end else begin
               w_state_nxt = S_WAIT0;
            end
         end
         S_WAIT0: w_state_nxt = w_cross ? S_ISSUE1 : S_DONE;
         S_ISSUE1: begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = w_widx + WIDX_W'(1);
            bus.mem_wdata = w_wdata1;
            if (r_we) begin
               bus.mem_we  = w_we1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WAIT1;
            end
         end
         S_WAIT1: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_err    <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_req_err;
         end
         if (r_state == S_WAIT0) r_rdata0 <= bus.mem_rdata;
         if (r_state == S_WAIT1) r_rdata1 <= bus.mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (r_err || r_we) ? 32'd0 : w_load_data;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: split and non-split LSU instances against a synchronous byte-strobed memory model.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(32)) bus_m ();
   load_store_unit_if #(.ADDR_W(32)) bus_n ();

   load_store_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus_m)
   );

   load_store_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_dut_ns (
      .clk (clk),
      .rst (rst_n),
      .bus (bus_n)
   );

   logic [31:0] mem [0:255];
   logic        poke_en;
   logic [7:0]  poke_idx;
   logic [31:0] poke_dat;

   always @(posedge clk) begin
      if (poke_en) begin
         mem[poke_idx] <= poke_dat;
      end else if (bus_m.mem_en) begin
         for (int i = 0; i < 4; i++)
            if (bus_m.mem_we[i])
               mem[bus_m.mem_addr[7:0]][8*i +: 8] <= bus_m.mem_wdata[8*i +: 8];
         bus_m.mem_rdata <= mem[bus_m.mem_addr[7:0]];
      end
   end

   assign bus_n.mem_rdata = 32'hCAFE_F00D;

   int          en_cnt = 0;
   int          ns_en_cnt = 0;
   int          rv_cnt = 0;
   logic [29:0] log_addr  [0:15];
   logic [3:0]  log_we    [0:15];
   logic [31:0] log_wdata [0:15];

   always @(negedge clk) begin
      if (bus_m.mem_en) begin
         log_addr[en_cnt[3:0]]  <= bus_m.mem_addr;
         log_we[en_cnt[3:0]]    <= bus_m.mem_we;
         log_wdata[en_cnt[3:0]] <= bus_m.mem_wdata;
         en_cnt <= en_cnt + 1;
      end
      if (bus_n.mem_en) ns_en_cnt <= ns_en_cnt + 1;
      if (bus_m.rsp_valid) rv_cnt <= rv_cnt + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = idx;
      poke_dat = dat;
      @(negedge clk);
      poke_en  = 1'b0;
   endtask

   task automatic do_req(input bit ns, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int n_en, output int base);
      int b;
      @(negedge clk);
      b = ns ? ns_en_cnt : en_cnt;
      if (ns) begin
         bus_n.req_valid = 1'b1; bus_n.req_we = we; bus_n.req_funct3 = f3;
         bus_n.req_addr = addr; bus_n.req_wdata = wdata;
      end else begin
         bus_m.req_valid = 1'b1; bus_m.req_we = we; bus_m.req_funct3 = f3;
         bus_m.req_addr = addr; bus_m.req_wdata = wdata;
      end
      @(posedge clk);
      #1;
      bus_m.req_valid = 1'b0;
      bus_n.req_valid = 1'b0;
      lat   = 0;
      rdata = 32'hDEAD_DEAD;
      err   = 1'bx;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (ns ? bus_n.rsp_valid : bus_m.rsp_valid) begin
            lat   = c;
            rdata = ns ? bus_n.rsp_rdata : bus_m.rsp_rdata;
            err   = ns ? bus_n.rsp_err : bus_m.rsp_err;
            break;
         end
      end
      n_en = (ns ? ns_en_cnt : en_cnt) - b;
      base = b;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_en;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, nen, b, b1, rv0;

      rst_n = 1'b0;
      poke_en = 1'b0; poke_idx = '0; poke_dat = '0;
      bus_m.req_valid = 1'b0; bus_m.req_we = 1'b0; bus_m.req_funct3 = '0;
      bus_m.req_addr = '0; bus_m.req_wdata = '0;
      bus_n.req_valid = 1'b0; bus_n.req_we = 1'b0; bus_n.req_funct3 = '0;
      bus_n.req_addr = '0; bus_n.req_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready",  32'(bus_m.req_ready), 32'd1);
      check("reset rsp_valid",  32'(bus_m.rsp_valid), 32'd0);
      check("reset rsp_rdata",  bus_m.rsp_rdata, 32'd0);
      check("reset rsp_err",    32'(bus_m.rsp_err), 32'd0);
      check("reset mem_en",     32'(bus_m.mem_en), 32'd0);
      check("reset mem_we",     32'(bus_m.mem_we), 32'd0);
      check("reset ns req_ready", 32'(bus_n.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      poke(8'h41, 32'h8000_FF00);
      poke(8'hC1, 32'h0000_0000);

      //              we    f3     addr       wdata         rdata          err  lat en
      vecs.push_back('{1'b0, F3_H,  32'h104, 32'h0,         32'hFFFF_FF00, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_HU, 32'h106, 32'h0,         32'h0000_8000, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_B,  32'h107, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_BU, 32'h107, 32'h0,         32'h0000_0080, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_B,  32'h105, 32'h0,         32'hFFFF_FFFF, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_W,  32'h104, 32'h0,         32'h8000_FF00, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_H,  32'h106, 32'h0,         32'hFFFF_8000, 1'b0, 3, 1});
      vecs.push_back('{1'b1, F3_W,  32'h300, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1});
      vecs.push_back('{1'b1, F3_B,  32'h301, 32'h0000_0055, 32'h0,         1'b0, 2, 1});
      vecs.push_back('{1'b1, F3_H,  32'h302, 32'hABCD_1234, 32'h0,         1'b0, 2, 1});
      vecs.push_back('{1'b0, F3_W,  32'h300, 32'h0,         32'h1234_55EF, 1'b0, 3, 1});
      vecs.push_back('{1'b0, F3_W,  32'h301, 32'h0,         32'h0012_3455, 1'b0, 5, 2});
      vecs.push_back('{1'b0, F3_HU, 32'h303, 32'h0,         32'h0000_0012, 1'b0, 5, 2});
      vecs.push_back('{1'b0, F3_B,  32'h303, 32'h0,         32'h0000_0012, 1'b0, 3, 1});
      vecs.push_back('{1'b0, 3'd3,  32'h104, 32'h0,         32'h0,         1'b1, 1, 0});
      vecs.push_back('{1'b1, 3'd4,  32'h100, 32'h1111_1111, 32'h0,         1'b1, 1, 0});
      vecs.push_back('{1'b1, F3_W,  32'h306, 32'h1122_3344, 32'h0,         1'b0, 3, 2});
      vecs.push_back('{1'b0, F3_W,  32'h306, 32'h0,         32'h1122_3344, 1'b0, 5, 2});
      vecs.push_back('{1'b0, F3_H,  32'h308, 32'h0,         32'h0000_1122, 1'b0, 3, 1});

      foreach (vecs[i]) begin
         do_req(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nen, b);
         check($sformatf("vec%0d rdata", i),   rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d err", i),     32'(er), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d mem_en", i),  nen, vecs[i].exp_en);
      end

      // Split LH across words 0x40/0x41
      poke(8'h40, 32'hAA00_0000);
      poke(8'h41, 32'h0000_00BB);
      do_req(1'b0, 1'b0, F3_H, 32'h103, 32'h0, rd, er, lat, nen, b);
      b1 = b + 1;
      check("split lh rdata",   rd, 32'hFFFF_BBAA);
      check("split lh latency", lat, 5);
      check("split lh mem_en",  nen, 2);
      check("split lh addr0",   32'(log_addr[b[3:0]]), 32'h40);
      check("split lh addr1",   32'(log_addr[b1[3:0]]), 32'h41);
      check("split lh we0",     32'(log_we[b[3:0]]), 32'h0);

      // Split SH 0x1234 to 0x203
      do_req(1'b0, 1'b1, F3_H, 32'h203, 32'h0000_1234, rd, er, lat, nen, b);
      b1 = b + 1;
      check("split sh latency", lat, 3);
      check("split sh mem_en",  nen, 2);
      check("split sh we0",     32'(log_we[b[3:0]]), 32'b1000);
      check("split sh addr0",   32'(log_addr[b[3:0]]), 32'h80);
      check("split sh wdata0",  32'(log_wdata[b[3:0]][31:24]), 32'h34);
      check("split sh we1",     32'(log_we[b1[3:0]]), 32'b0001);
      check("split sh addr1",   32'(log_addr[b1[3:0]]), 32'h81);
      check("split sh wdata1",  32'(log_wdata[b1[3:0]][7:0]), 32'h12);
      check("split sh mem80",   32'(mem[8'h80][31:24]), 32'h34);
      check("split sh mem81",   32'(mem[8'h81][7:0]), 32'h12);

      // Non-split instance: misaligned and illegal become errors without memory access
      do_req(1'b1, 1'b0, F3_W, 32'h2, 32'h0, rd, er, lat, nen, b);
      check("ns lw misal err",   32'(er), 32'd1);
      check("ns lw misal rdata", rd, 32'd0);
      check("ns lw misal lat",   lat, 1);
      check("ns lw misal mem_en", nen, 0);
      do_req(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, rd, er, lat, nen, b);
      check("ns f3=3 err",    32'(er), 32'd1);
      check("ns f3=3 lat",    lat, 1);
      check("ns f3=3 mem_en", nen, 0);
      do_req(1'b1, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat, nen, b);
      check("ns lw ok rdata",  rd, 32'hCAFE_F00D);
      check("ns lw ok err",    32'(er), 32'd0);
      check("ns lw ok lat",    lat, 3);
      check("ns lw ok mem_en", nen, 1);
      do_req(1'b1, 1'b1, F3_H, 32'h1, 32'h5555, rd, er, lat, nen, b);
      check("ns sh misal err",    32'(er), 32'd1);
      check("ns sh misal mem_en", nen, 0);

      // Reset during WAIT0 of a split load
      @(negedge clk);
      bus_m.req_valid = 1'b1; bus_m.req_we = 1'b0; bus_m.req_funct3 = F3_H;
      bus_m.req_addr = 32'h103; bus_m.req_wdata = '0;
      @(posedge clk);
      #1;
      bus_m.req_valid = 1'b0;
      @(posedge clk);
      #2;
      check("busy req_ready", 32'(bus_m.req_ready), 32'd0);
      rv0 = rv_cnt;
      rst_n = 1'b0;
      #1;
      check("rst wait0 mem_en",    32'(bus_m.mem_en), 32'd0);
      check("rst wait0 req_ready", 32'(bus_m.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rst no rsp_valid", rv_cnt - rv0, 0);
      do_req(1'b0, 1'b0, F3_W, 32'h104, 32'h0, rd, er, lat, nen, b);
      check("post-rst lw rdata", rd, 32'h0000_00BB);
      check("post-rst lw err",   32'(er), 32'd0);
      check("post-rst lw lat",   lat, 3);

      // Reset during ISSUE0 of a store: mem_en must drop without a clock edge
      @(negedge clk);
      bus_m.req_valid = 1'b1; bus_m.req_we = 1'b1; bus_m.req_funct3 = F3_W;
      bus_m.req_addr = 32'h3F0; bus_m.req_wdata = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      bus_m.req_valid = 1'b0;
      check("issue0 mem_en", 32'(bus_m.mem_en), 32'd1);
      check("issue0 mem_we", 32'(bus_m.mem_we), 32'hF);
      rst_n = 1'b0;
      #1;
      check("rst issue0 mem_en", 32'(bus_m.mem_en), 32'd0);
      check("rst issue0 mem_we", 32'(bus_m.mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
